// File: rtl/buffer_unit_pkg.sv
// Shared types for the router input-port flit buffer: FSM state encodings and default sizing.
package buffer_unit_pkg;

  localparam int DATA_WIDTH_DFLT = 18;
  localparam int DEPTH_DFLT      = 64;

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ_SW,
    OUT_SEND,
    OUT_WAIT
  } out_state_t;

endpackage

// File: rtl/buffer_unit_flit_fifo.sv
// Circular flit store, combinational read of the head entry, registered pointers/count.
// Push and pop in the same cycle are both honoured; the caller never pushes when full or pops when empty.
module flit_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/buffer_unit.sv
// NoC input-port buffer: 4-phase req/ack in, switch-allocator req/grant, 4-phase req/ack out.
// Input ack is withheld while the FIFO is full; all outputs are registered.
module buffer_unit
  import buffer_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DFLT,
  parameter int MAX_PACKET_SIZE = DEPTH_DFLT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_req,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ack,
  output logic                  o_out_req,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ack,
  output logic                  o_sw_req,
  input  logic                  i_sw_grant
);

  in_state_t             r_in_state, w_in_state_nxt;
  out_state_t            r_out_state, w_out_state_nxt;
  logic                  r_in_ack, w_in_ack_nxt;
  logic                  r_out_req, w_out_req_nxt;
  logic                  r_sw_req, w_sw_req_nxt;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic                  w_push, w_pop;
  logic                  w_full, w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  flit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_PACKET_SIZE)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_in_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_state  <= IN_IDLE;
      r_out_state <= OUT_IDLE;
      r_in_ack    <= 1'b0;
      r_out_req   <= 1'b0;
      r_sw_req    <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_out_state <= w_out_state_nxt;
      r_in_ack    <= w_in_ack_nxt;
      r_out_req   <= w_out_req_nxt;
      r_sw_req    <= w_sw_req_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  // Upstream side: the write happens on the same edge that raises ack.
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_in_ack_nxt   = r_in_ack;
    w_push         = 1'b0;
    case (r_in_state)
      IN_IDLE: begin
        if (i_in_req && !w_full) begin
          w_push         = 1'b1;
          w_in_ack_nxt   = 1'b1;
          w_in_state_nxt = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!i_in_req) begin
          w_in_ack_nxt   = 1'b0;
          w_in_state_nxt = IN_IDLE;
        end
      end
      default: w_in_state_nxt = IN_IDLE;
    endcase
  end

  // Downstream side: the head is popped only once the receiver has acked it.
  always_comb begin
    w_out_state_nxt = r_out_state;
    w_out_req_nxt   = r_out_req;
    w_sw_req_nxt    = r_sw_req;
    w_out_data_nxt  = r_out_data;
    w_pop           = 1'b0;
    case (r_out_state)
      OUT_IDLE: begin
        if (!w_empty) begin
          w_sw_req_nxt    = 1'b1;
          w_out_state_nxt = OUT_REQ_SW;
        end
      end
      OUT_REQ_SW: begin
        if (i_sw_grant) begin
          w_out_data_nxt  = w_head;
          w_out_req_nxt   = 1'b1;
          w_sw_req_nxt    = 1'b0;
          w_out_state_nxt = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (i_out_ack) begin
          w_out_req_nxt   = 1'b0;
          w_pop           = 1'b1;
          w_out_state_nxt = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!i_out_ack) w_out_state_nxt = OUT_IDLE;
      end
      default: w_out_state_nxt = OUT_IDLE;
    endcase
  end

  assign o_in_ack   = r_in_ack;
  assign o_out_req  = r_out_req;
  assign o_out_data = r_out_data;
  assign o_sw_req   = r_sw_req;

endmodule

// File: tb/tb_buffer_unit.sv
// Scoreboard bench for buffer_unit: upstream and downstream 4-phase agents around a flit queue.
module tb_buffer_unit;

  localparam int DW    = 18;
  localparam int DEPTH = 64;
  localparam int TMO   = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_req = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ack;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          out_ack = 1'b0;
  logic          sw_req;
  logic          sw_grant = 1'b0;

  int            vectors = 0;
  int            miscompares = 0;
  int            max_count = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  buffer_unit #(
    .DATA_WIDTH      (DW),
    .MAX_PACKET_SIZE (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_req   (in_req),
    .i_in_data  (in_data),
    .o_in_ack   (in_ack),
    .o_out_req  (out_req),
    .o_out_data (out_data),
    .i_out_ack  (out_ack),
    .o_sw_req   (sw_req),
    .i_sw_grant (sw_grant)
  );

  always @(negedge clk) begin
    if (mon_en && int'(dut.u_fifo.r_count) > max_count) max_count = int'(dut.u_fifo.r_count);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full upstream 4-phase cycle; called at a negedge, returns at a negedge.
  task automatic push_flit(input logic [DW-1:0] d);
    int n = 0;
    in_data = d;
    in_req  = 1'b1;
    sb.push_back(d);
    do begin @(negedge clk); n++; end while (!in_ack && n < TMO);
    chk("push_ack", 32'(in_ack), 1);
    in_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (in_ack && n < TMO);
    chk("push_ack_drop", 32'(in_ack), 0);
  endtask

  // Allocator grant plus downstream 4-phase cycle, comparing against the scoreboard head.
  task automatic pull_flit(input int gd, input int ad);
    int            n = 0;
    logic [DW-1:0] exp;
    while (!sw_req && n < TMO) begin @(negedge clk); n++; end
    chk("sw_req_up", 32'(sw_req), 1);
    repeat (gd) @(negedge clk);
    sw_grant = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_req && n < TMO);
    sw_grant = 1'b0;
    chk("out_req_up", 32'(out_req), 1);
    chk("sw_req_clr", 32'(sw_req), 0);
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    repeat (ad) @(negedge clk);
    chk("out_data", 32'(out_data), 32'(exp));
    out_ack = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (out_req && n < TMO);
    chk("out_req_drop", 32'(out_req), 0);
    out_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;

    // Reset with all inputs low
    repeat (2) @(negedge clk);
    chk("rst_in_ack", 32'(in_ack), 0);
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_sw_req", 32'(sw_req), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_empty", 32'(dut.u_fifo.o_empty), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single flit, exact handshake timing
    in_data = 18'd347;
    in_req  = 1'b1;
    sb.push_back(18'd347);
    @(negedge clk);
    chk("t1_ack_rise", 32'(in_ack), 1);
    in_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_fall", 32'(in_ack), 0);
    chk("t1_sw_req", 32'(sw_req), 1);
    pull_flit(0, 1);
    chk("t1_empty", 32'(dut.u_fifo.o_empty), 1);
    chk("t1_sw_idle", 32'(sw_req), 0);
    @(negedge clk);
    chk("t1_sw_idle2", 32'(sw_req), 0);

    // Fill to capacity with the allocator silent
    for (int i = 0; i < DEPTH; i++) push_flit(DW'(i));
    chk("full_count", 32'(dut.u_fifo.r_count), DEPTH);
    chk("full_flag", 32'(dut.u_fifo.o_full), 1);
    in_data = 18'h2AAAA;
    in_req  = 1'b1;
    sb.push_back(18'h2AAAA);
    repeat (4) @(negedge clk);
    chk("full_no_ack", 32'(in_ack), 0);
    pull_flit(0, 0);
    n = 0;
    while (!in_ack && n < TMO) begin @(negedge clk); n++; end
    chk("full_late_ack", 32'(in_ack), 1);
    in_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (in_ack && n < TMO);
    chk("full_late_drop", 32'(in_ack), 0);
    for (int i = 0; i < DEPTH; i++) pull_flit(0, 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);
    chk("drain_empty", 32'(dut.u_fifo.o_empty), 1);

    // Concurrent random traffic
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_flit(DW'($urandom));
        end
      end
      begin
        for (int j = 0; j < 200; j++) pull_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    join
    mon_en = 1'b0;
    chk("rand_max_count", 32'(max_count <= DEPTH), 1);
    chk("rand_sb_empty", 32'(sb.size()), 0);
    chk("rand_empty", 32'(dut.u_fifo.o_empty), 1);

    // Reset while sending with 5 flits stored and an upstream write mid-handshake
    for (int i = 0; i < 5; i++) push_flit(DW'(100 + i));
    n = 0;
    while (!sw_req && n < TMO) begin @(negedge clk); n++; end
    sw_grant = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_req && n < TMO);
    sw_grant = 1'b0;
    chk("rs_in_send", 32'(out_req), 1);
    in_data = 18'd999;
    in_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ack && n < TMO);
    chk("rs_in_ack", 32'(in_ack), 1);
    rst    = 1'b1;
    in_req = 1'b0;
    @(negedge clk);
    chk("rs_out_req", 32'(out_req), 0);
    chk("rs_in_ack0", 32'(in_ack), 0);
    chk("rs_sw_req", 32'(sw_req), 0);
    chk("rs_empty", 32'(dut.u_fifo.o_empty), 1);
    rst = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rs_no_req", 32'(sw_req), 0);
    push_flit(18'd123);
    pull_flit(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
